mca_add_sub_multilane: RTL

- Parametrised successor of the FIR multi-cycle add/sub accumulator.
- Sums NUM_ADDITIONS signed coefficients, each added or subtracted according to its S bit, processing LANES operands per clock.
- Operands are captured at start, so the caller may change them during the operation. Completion is flagged by a busy/done handshake.
- Output is selectable between wrap and saturate; sits between the coefficient/S-value buffers and the downsampled FIR output stage.

---
 rtl/FIR_pkg.sv | 19 +
 rtl/mca_add_sub_multilane_lane_sum.sv | 24 ++
 rtl/mca_add_sub_multilane.sv | 126 ++++++++++++
 3 files changed

// File: rtl/FIR_pkg.sv
// rtl/FIR_pkg.sv - shared FIR types and helpers for the multi-cycle add/sub accumulators
package FIR_pkg;

  typedef enum logic {MCA_IDLE, MCA_ADDING} state_mca_e;

  typedef enum logic {MCA_ML_IDLE, MCA_ML_ADDING} state_mca_ml_e;

  // Clamp a signed value to the signed range of `width` bits (width <= 64).
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value, input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mca_add_sub_multilane_lane_sum.sv
// rtl/mca_add_sub_multilane_lane_sum.sv - combinational signed add/sub of one beat's lanes
module mca_lane_sum #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int WIDTH_ACC         = 37,
  parameter int LANES             = 4
) (
  input  logic signed [WIDTH_COEFFICIENT-1:0] i_ops [LANES],
  input  logic [LANES-1:0]                    i_s,
  input  logic [LANES-1:0]                    i_valid,
  output logic signed [WIDTH_ACC-1:0]         o_sum
);

  always_comb begin
    logic signed [WIDTH_ACC-1:0] w_term;
    o_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_term = WIDTH_ACC'(i_ops[l]);
      if (i_valid[l]) begin
        o_sum = i_s[l] ? (o_sum + w_term) : (o_sum - w_term);
      end
    end
  end

endmodule

// File: rtl/mca_add_sub_multilane.sv
// rtl/mca_add_sub_multilane.sv - multi-lane multi-cycle signed add/sub accumulator
module mca_add_sub_multilane
  import FIR_pkg::*;
#(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int NUM_ADDITIONS     = 16,
  parameter int LANES             = 4,
  parameter int SATURATE          = 0,
  parameter int CLEAR_ON_DISABLE  = 1
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                enable,
  input  logic                                start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] operands [NUM_ADDITIONS],
  input  logic [NUM_ADDITIONS-1:0]            S_values,
  output logic                                busy,
  output logic                                done,
  output logic signed [WIDTH_COEFFICIENT-1:0] res
);

  localparam int BEATS     = (NUM_ADDITIONS + LANES - 1) / LANES;
  localparam int WIDTH_ACC = WIDTH_COEFFICIENT + $clog2(NUM_ADDITIONS) + 1;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_mca_ml_e                        r_state;
  state_mca_ml_e                        w_next_state;
  logic [BEAT_W-1:0]                    r_beat;
  logic signed [WIDTH_ACC-1:0]          r_acc;
  logic signed [WIDTH_COEFFICIENT-1:0]  r_ops [NUM_ADDITIONS];
  logic [NUM_ADDITIONS-1:0]             r_s;
  logic signed [WIDTH_COEFFICIENT-1:0]  r_res;
  logic                                 r_done;

  logic signed [WIDTH_COEFFICIENT-1:0]  w_lane_ops [LANES];
  logic [LANES-1:0]                     w_lane_s;
  logic [LANES-1:0]                     w_lane_valid;
  logic signed [WIDTH_ACC-1:0]          w_lane_sum;
  logic signed [WIDTH_ACC-1:0]          w_final;
  logic signed [WIDTH_COEFFICIENT-1:0]  w_res_next;
  logic                                 w_last;

  assign busy   = (r_state == MCA_ML_ADDING);
  assign done   = r_done;
  assign res    = r_res;
  assign w_last = (r_beat == BEAT_W'(BEATS - 1));

  // Lanes whose index runs past NUM_ADDITIONS stay invalid and add nothing.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_ops[l]   = '0;
      w_lane_s[l]     = 1'b0;
      w_lane_valid[l] = 1'b0;
      for (int i = 0; i < NUM_ADDITIONS; i++) begin
        if (i == int'(r_beat) * LANES + l) begin
          w_lane_ops[l]   = r_ops[i];
          w_lane_s[l]     = r_s[i];
          w_lane_valid[l] = 1'b1;
        end
      end
    end
  end

  mca_lane_sum #(
    .WIDTH_COEFFICIENT(WIDTH_COEFFICIENT),
    .WIDTH_ACC        (WIDTH_ACC),
    .LANES            (LANES)
  ) u_lane_sum (
    .i_ops  (w_lane_ops),
    .i_s    (w_lane_s),
    .i_valid(w_lane_valid),
    .o_sum  (w_lane_sum)
  );

  assign w_final    = r_acc + w_lane_sum;
  assign w_res_next = WIDTH_COEFFICIENT'((SATURATE != 0) ? sat_trunc(64'(w_final), WIDTH_COEFFICIENT)
                                                        : 64'(w_final));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      MCA_ML_IDLE:   if (enable && start)  w_next_state = MCA_ML_ADDING;
      MCA_ML_ADDING: if (enable && w_last) w_next_state = MCA_ML_IDLE;
      default:       w_next_state = MCA_ML_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MCA_ML_IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_beat <= '0;
      r_acc  <= '0;
      for (int i = 0; i < NUM_ADDITIONS; i++) r_ops[i] <= '0;
      r_s    <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else if (enable) begin
      r_done <= 1'b0;
      if (r_state == MCA_ML_IDLE) begin
        if (start) begin
          r_ops  <= operands;
          r_s    <= S_values;
          r_acc  <= '0;
          r_beat <= '0;
        end
      end else begin
        r_acc <= w_final;
        if (w_last) begin
          r_res  <= w_res_next;
          r_done <= 1'b1;
          r_beat <= '0;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
    end else if (CLEAR_ON_DISABLE != 0) begin
      r_res  <= '0;
      r_done <= 1'b0;
    end
  end

endmodule
